// File: rtl/rv_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : rv_decode_stage_if
// Purpose  : Fetch-side and execute-side handshake bundle of the RV32I/RV64I
//            decode stage.
// Ports    : in_valid/in_ready/in_instr/in_pc    fetch -> decode
//            out_valid/out_ready/out_*           decode -> register read
//            modport slave  : the decode stage
//            modport master : the environment (fetch + downstream)
// Revision : 1.0 - initial release
// ============================================================================
interface rv_decode_stage_if #(
  parameter int XLEN = 32
);
  // Fetch side
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  // Decoded side
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_rd_we;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_rd_we, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_rd_we, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/rv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv_decode_stage
// Purpose  : Registered, handshaked RV32I/RV64I instruction decode. Splits the
//            instruction into fields, classifies its format, assembles the
//            sign-extended immediate and carries the PC. A two-entry skid
//            (output register + skid register) gives one instruction per
//            cycle with a registered in_ready.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            flush  - synchronous discard of all held entries
//            bus    - rv_decode_stage_if.slave (fetch in / decoded out)
// Params   : XLEN         - 32 or 64
//            ILLEGAL_ON_C - 1: instr[1:0]!=2'b11 is illegal; 0: ignored
// Revision : 1.0 - initial release
// ============================================================================
module rv_decode_stage #(
  parameter int XLEN         = 32,
  parameter bit ILLEGAL_ON_C = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  rv_decode_stage_if.slave bus
);

  // Format codes presented on out_fmt
  localparam logic [2:0] c_fmt_r   = 3'd0;
  localparam logic [2:0] c_fmt_i   = 3'd1;
  localparam logic [2:0] c_fmt_s   = 3'd2;
  localparam logic [2:0] c_fmt_b   = 3'd3;
  localparam logic [2:0] c_fmt_u   = 3'd4;
  localparam logic [2:0] c_fmt_j   = 3'd5;
  localparam logic [2:0] c_fmt_ill = 3'd7;

  // Base opcodes
  localparam logic [6:0] c_op_op      = 7'b0110011;
  localparam logic [6:0] c_op_load    = 7'b0000011;
  localparam logic [6:0] c_op_opimm   = 7'b0010011;
  localparam logic [6:0] c_op_jalr    = 7'b1100111;
  localparam logic [6:0] c_op_miscmem = 7'b0001111;
  localparam logic [6:0] c_op_system  = 7'b1110011;
  localparam logic [6:0] c_op_store   = 7'b0100011;
  localparam logic [6:0] c_op_branch  = 7'b1100011;
  localparam logic [6:0] c_op_lui     = 7'b0110111;
  localparam logic [6:0] c_op_auipc   = 7'b0010111;
  localparam logic [6:0] c_op_jal     = 7'b1101111;

  // One decoded entry; used for both the output and the skid register
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            rd_we;
    logic            illegal;
  } dec_t;

  // EMPTY: nothing held. ONE: output register valid. FULL: output + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_in_ready;
  dec_t            r_out;
  dec_t            r_skid;

  dec_t            w_dec;
  logic            w_writes;
  logic [31:0]     w_instr;
  logic [6:0]      w_opkey;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic            w_accept;
  logic            w_xfer;
  logic            w_load_out_dec;
  logic            w_load_out_skid;
  logic            w_load_skid;

  // --------------------------------------------------------------------------
  // Combinational decode of the instruction currently offered by fetch
  // --------------------------------------------------------------------------
  assign w_instr = bus.in_instr;

  // With the low-bit check disabled the compressed-quadrant bits are forced
  // to 2'b11 so classification only looks at instr[6:2].
  assign w_opkey = {w_instr[6:2], (ILLEGAL_ON_C ? w_instr[1:0] : 2'b11)};

  // Every immediate's sign bit is instr[31]; the signed size cast extends it.
  assign w_imm_i = XLEN'($signed(w_instr[31:20]));
  assign w_imm_s = XLEN'($signed({w_instr[31:25], w_instr[11:7]}));
  assign w_imm_b = XLEN'($signed({w_instr[31], w_instr[7], w_instr[30:25],
                                  w_instr[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({w_instr[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({w_instr[31], w_instr[19:12], w_instr[20],
                                  w_instr[30:21], 1'b0}));

  always_comb begin
    w_dec        = '0;
    w_writes     = 1'b0;
    w_dec.pc     = bus.in_pc;
    w_dec.opcode = w_instr[6:0];
    w_dec.funct3 = w_instr[14:12];
    w_dec.fmt    = c_fmt_ill;

    case (w_opkey)
      c_op_op: begin
        w_dec.fmt    = c_fmt_r;
        w_dec.rd     = w_instr[11:7];
        w_dec.rs1    = w_instr[19:15];
        w_dec.rs2    = w_instr[24:20];
        w_dec.funct7 = w_instr[31:25];
        w_writes     = 1'b1;
      end
      c_op_load, c_op_opimm, c_op_jalr, c_op_miscmem, c_op_system: begin
        w_dec.fmt = c_fmt_i;
        w_dec.rd  = w_instr[11:7];
        w_dec.rs1 = w_instr[19:15];
        w_dec.imm = w_imm_i;
        w_writes  = 1'b1;
      end
      c_op_store: begin
        w_dec.fmt = c_fmt_s;
        w_dec.rs1 = w_instr[19:15];
        w_dec.rs2 = w_instr[24:20];
        w_dec.imm = w_imm_s;
      end
      c_op_branch: begin
        w_dec.fmt = c_fmt_b;
        w_dec.rs1 = w_instr[19:15];
        w_dec.rs2 = w_instr[24:20];
        w_dec.imm = w_imm_b;
      end
      c_op_lui, c_op_auipc: begin
        w_dec.fmt    = c_fmt_u;
        w_dec.rd     = w_instr[11:7];
        w_dec.funct3 = 3'd0;
        w_dec.imm    = w_imm_u;
        w_writes     = 1'b1;
      end
      c_op_jal: begin
        w_dec.fmt    = c_fmt_j;
        w_dec.rd     = w_instr[11:7];
        w_dec.funct3 = 3'd0;
        w_dec.imm    = w_imm_j;
        w_writes     = 1'b1;
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase

    // Writes to x0 are architecturally discarded, so never request them.
    w_dec.rd_we = w_writes & (w_dec.rd != 5'd0);
  end

  // --------------------------------------------------------------------------
  // Skid control: next state and register load enables
  // --------------------------------------------------------------------------
  assign w_accept = bus.in_valid & r_in_ready;
  assign w_xfer   = (r_state != ST_EMPTY) & bus.out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_dec  = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;

    if (flush) begin
      // Flush overrides both a concurrent accept and a concurrent transfer.
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt    = ST_ONE;
            w_load_out_dec = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_xfer) begin
            w_load_out_dec = 1'b1;
          end else if (w_accept) begin
            // Output is stalled; park the new decode behind it.
            w_state_nxt = ST_FULL;
            w_load_skid = 1'b1;
          end else if (w_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so no accept can coincide.
          if (w_xfer) begin
            w_state_nxt     = ST_ONE;
            w_load_out_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State, ready and data registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // in_ready is its own flop (low only while the skid is occupied) so it
  // never has a combinational path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_out_dec) begin
        r_out <= w_dec;
      end else if (w_load_out_skid) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = (r_state != ST_EMPTY);
  assign bus.out_pc      = r_out.pc;
  assign bus.out_opcode  = r_out.opcode;
  assign bus.out_rd      = r_out.rd;
  assign bus.out_rs1     = r_out.rs1;
  assign bus.out_rs2     = r_out.rs2;
  assign bus.out_funct3  = r_out.funct3;
  assign bus.out_funct7  = r_out.funct7;
  assign bus.out_imm     = r_out.imm;
  assign bus.out_fmt     = r_out.fmt;
  assign bus.out_rd_we   = r_out.rd_we;
  assign bus.out_illegal = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_rv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_decode_stage
// Purpose  : Scoreboard bench for rv_decode_stage. Two instances run in
//            lockstep from the same stimulus: XLEN=32 with the low-bit check
//            enabled, and XLEN=64 with it disabled. Expected entries come
//            from a field-arithmetic reference model and are queued on
//            accept; a monitor compares the queue head whenever out_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_decode_stage;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  rv_decode_stage_if #(.XLEN(32)) bus_a ();
  rv_decode_stage_if #(.XLEN(64)) bus_b ();

  rv_decode_stage #(.XLEN(32), .ILLEGAL_ON_C(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus_a)
  );

  rv_decode_stage #(.XLEN(64), .ILLEGAL_ON_C(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus_b)
  );

  typedef struct {
    logic [63:0] pc;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [63:0] pc     = 64'h8000_0000_0000_1000;

  // Reference decode: immediates built by weighted sums of instruction
  // fields, with the sign carried by an arithmetic shift of the whole word.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] ipc,
                                 input bit wide, input bit illc);
    exp_t        e;
    longint      w;
    longint      hi;
    logic [6:0]  op;
    w  = longint'($signed(ins));
    hi = w >>> 31;
    op = ins[6:0];
    if (!illc) op[1:0] = 2'b11;
    e.pc  = ipc;   e.opc = ins[6:0]; e.rd  = 5'd0; e.rs1 = 5'd0; e.rs2 = 5'd0;
    e.f3  = ins[14:12]; e.f7 = 7'd0; e.imm = 64'd0; e.fmt = 3'd7;
    e.we  = 1'b0;  e.ill = 1'b0;
    case (op)
      7'b0110011: begin
        e.fmt = 3'd0; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        e.f7  = ins[31:25];
      end
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        e.fmt = 3'd1; e.rd = ins[11:7]; e.rs1 = ins[19:15];
        e.imm = w >>> 20;
      end
      7'b0100011: begin
        e.fmt = 3'd2; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        e.imm = (w >>> 25) * 32 + longint'(ins[11:7]);
      end
      7'b1100011: begin
        e.fmt = 3'd3; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        e.imm = hi * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
              + longint'(ins[11:8]) * 2;
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = 3'd4; e.rd = ins[11:7]; e.f3 = 3'd0;
        e.imm = (w >>> 12) * 4096;
      end
      7'b1101111: begin
        e.fmt = 3'd5; e.rd = ins[11:7]; e.f3 = 3'd0;
        e.imm = hi * 1048576 + longint'(ins[19:12]) * 4096
              + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      end
      default: e.ill = 1'b1;
    endcase
    e.we = (e.fmt == 3'd0 || e.fmt == 3'd1 || e.fmt == 3'd4 || e.fmt == 3'd5)
           && (e.rd != 5'd0);
    if (!wide) begin
      e.imm = {32'd0, e.imm[31:0]};
      e.pc  = {32'd0, ipc[31:0]};
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic cmp_entry(input string tag, input exp_t g, input exp_t e);
    cmp({tag, ".pc"},      g.pc,  e.pc);
    cmp({tag, ".opcode"},  64'(g.opc), 64'(e.opc));
    cmp({tag, ".rd"},      64'(g.rd),  64'(e.rd));
    cmp({tag, ".rs1"},     64'(g.rs1), 64'(e.rs1));
    cmp({tag, ".rs2"},     64'(g.rs2), 64'(e.rs2));
    cmp({tag, ".funct3"},  64'(g.f3),  64'(e.f3));
    cmp({tag, ".funct7"},  64'(g.f7),  64'(e.f7));
    cmp({tag, ".imm"},     g.imm, e.imm);
    cmp({tag, ".fmt"},     64'(g.fmt), 64'(e.fmt));
    cmp({tag, ".rd_we"},   64'(g.we),  64'(e.we));
    cmp({tag, ".illegal"}, 64'(g.ill), 64'(e.ill));
  endtask

  function automatic exp_t grab_a();
    exp_t g;
    g.pc = 64'(bus_a.out_pc);   g.opc = bus_a.out_opcode; g.rd = bus_a.out_rd;
    g.rs1 = bus_a.out_rs1;      g.rs2 = bus_a.out_rs2;    g.f3 = bus_a.out_funct3;
    g.f7 = bus_a.out_funct7;    g.imm = 64'(bus_a.out_imm); g.fmt = bus_a.out_fmt;
    g.we = bus_a.out_rd_we;     g.ill = bus_a.out_illegal;
    return g;
  endfunction

  function automatic exp_t grab_b();
    exp_t g;
    g.pc = bus_b.out_pc;        g.opc = bus_b.out_opcode; g.rd = bus_b.out_rd;
    g.rs1 = bus_b.out_rs1;      g.rs2 = bus_b.out_rs2;    g.f3 = bus_b.out_funct3;
    g.f7 = bus_b.out_funct7;    g.imm = bus_b.out_imm;    g.fmt = bus_b.out_fmt;
    g.we = bus_b.out_rd_we;     g.ill = bus_b.out_illegal;
    return g;
  endfunction

  // Monitor: handshake expectations follow from the number of entries held
  // (accepted, not yet transferred); data compared against the oldest one.
  always @(negedge clk) begin
    if (rst_n) begin
      cmp("a.out_valid", 64'(bus_a.out_valid), 64'(q_a.size() != 0));
      cmp("a.in_ready",  64'(bus_a.in_ready),  64'(q_a.size() < 2));
      cmp("b.out_valid", 64'(bus_b.out_valid), 64'(q_b.size() != 0));
      cmp("b.in_ready",  64'(bus_b.in_ready),  64'(q_b.size() < 2));
      if (bus_a.out_valid && q_a.size() != 0) cmp_entry("a", grab_a(), q_a[0]);
      if (bus_b.out_valid && q_b.size() != 0) cmp_entry("b", grab_b(), q_b[0]);
      if (flush) begin
        q_a.delete();
        q_b.delete();
      end else begin
        if (bus_a.out_valid && bus_a.out_ready && q_a.size() != 0) void'(q_a.pop_front());
        if (bus_b.out_valid && bus_b.out_ready && q_b.size() != 0) void'(q_b.pop_front());
      end
    end
  end

  // Scoreboard feed: runs just after the monitor so held counts stay consistent.
  always @(negedge clk) begin
    #1;
    if (rst_n && !flush) begin
      if (bus_a.in_valid && bus_a.in_ready)
        q_a.push_back(model(bus_a.in_instr, 64'(bus_a.in_pc), 1'b0, 1'b1));
      if (bus_b.in_valid && bus_b.in_ready)
        q_b.push_back(model(bus_b.in_instr, bus_b.in_pc, 1'b1, 1'b0));
    end
  end

  // Drive one cycle; called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit v, input logic [31:0] ins, input bit ordy,
                      input bit fl, output bit acc);
    bus_a.in_valid = v;  bus_a.in_instr = ins; bus_a.in_pc = pc[31:0]; bus_a.out_ready = ordy;
    bus_b.in_valid = v;  bus_b.in_instr = ins; bus_b.in_pc = pc;       bus_b.out_ready = ordy;
    flush = fl;
    acc = v && !fl && bus_a.in_ready;
    @(posedge clk);
    #1;
    if (acc) pc = pc + 64'd4;
  endtask

  task automatic send(input logic [31:0] ins);
    bit acc;
    int guard;
    guard = 0;
    do begin
      step(1'b1, ins, 1'b1, 1'b0, acc);
      guard++;
    end while (!acc && guard < 50);
    if (!acc) cmp("send.timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] gen();
    logic [6:0]  ops[11];
    logic [31:0] r;
    int          k;
    ops = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011,
            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    r = $urandom;
    k = $urandom_range(0, 7);
    if (k >= 2) r[6:0] = ops[$urandom_range(0, 10)];
    if (k == 1) begin
      r[6:0] = ops[$urandom_range(0, 10)];
      r[1:0] = 2'($urandom_range(0, 2));
    end
    return r;
  endfunction

  initial begin
    bit          acc;
    int          c;
    int          sent;
    logic [31:0] dir[6];
    logic [31:0] b2b[8];
    logic [31:0] cur;

    bus_a.in_valid = 1'b0; bus_a.in_instr = 32'd0; bus_a.in_pc = 32'd0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_instr = 32'd0; bus_b.in_pc = 64'd0; bus_b.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst.a.out_valid", 64'(bus_a.out_valid), 64'd0);
    cmp("rst.a.in_ready",  64'(bus_a.in_ready),  64'd1);
    cmp("rst.a.out_imm",   64'(bus_a.out_imm),   64'd0);
    cmp("rst.a.out_pc",    64'(bus_a.out_pc),    64'd0);
    cmp("rst.a.out_rd",    64'(bus_a.out_rd),    64'd0);
    cmp("rst.a.out_fmt",   64'(bus_a.out_fmt),   64'd0);
    cmp("rst.b.out_valid", 64'(bus_b.out_valid), 64'd0);
    cmp("rst.b.in_ready",  64'(bus_b.in_ready),  64'd1);
    cmp("rst.b.out_imm",   bus_b.out_imm,        64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed decodes: addi -1, beq -4, jal 0, unknown opcode, addi with
    // low bits 01, plain addi.
    dir = '{32'hFFF00093, 32'hFE000EE3, 32'h0000006F, 32'h0000007F,
            32'h00000011, 32'h00000013};
    foreach (dir[i]) send(dir[i]);
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0, acc);

    // Back-to-back eight with the output stalled on cycles 2..4.
    foreach (b2b[i]) b2b[i] = gen();
    c = 0;
    sent = 0;
    while (sent < 8 && c < 40) begin
      step(1'b1, b2b[sent], !(c >= 2 && c <= 4), 1'b0, acc);
      if (acc) sent++;
      c++;
    end
    if (sent != 8) cmp("b2b.timeout", 64'(sent), 64'd8);
    repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0, acc);

    // Flush while FULL with a concurrent in_valid.
    step(1'b1, gen(), 1'b0, 1'b0, acc);
    step(1'b1, gen(), 1'b0, 1'b0, acc);
    step(1'b1, gen(), 1'b0, 1'b1, acc);
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0, acc);

    // Asynchronous reset mid-stream while FULL.
    step(1'b1, gen(), 1'b0, 1'b0, acc);
    step(1'b1, gen(), 1'b0, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst.a.out_valid", 64'(bus_a.out_valid), 64'd0);
    cmp("arst.a.in_ready",  64'(bus_a.in_ready),  64'd1);
    cmp("arst.b.out_valid", 64'(bus_b.out_valid), 64'd0);
    cmp("arst.b.in_ready",  64'(bus_b.in_ready),  64'd1);
    q_a.delete();
    q_b.delete();
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(gen());
    step(1'b0, 32'd0, 1'b1, 1'b0, acc);

    // Randomized traffic with random stalls and occasional flushes.
    cur = gen();
    for (int i = 0; i < 1500; i++) begin
      bit v, ordy, fl;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 39) == 0);
      step(v, cur, ordy, fl, acc);
      if (acc || fl) cur = gen();
    end
    repeat (6) step(1'b0, 32'd0, 1'b1, 1'b0, acc);
    cmp("drain.a", 64'(q_a.size()), 64'd0);
    cmp("drain.b", 64'(q_b.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered, handshaked RV32I/RV64I instruction-decode stage between fetch and register-read/execute.
- Splits the instruction into fields and classifies its format.
- Produces a fully assembled, sign-extended XLEN immediate, write-enable and illegal flags, and carries the PC alongside.
- A 2-entry skid buffer gives full throughput with registered in_ready; a synchronous flush supports branch redirect.

Parameters:
XLEN, 32, datapath/immediate/PC width; legal values 32 or 64
ILLEGAL_ON_C, 1, 1: instruction[1:0]!=2'b11 is flagged illegal; 0: low bits ignored

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; discards all held entries
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept; registered
in_instr  in  32  raw instruction
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  decoded entry is presented
out_ready  in  1  downstream accepts
out_pc  out  XLEN  PC passthrough
out_opcode  out  7  instr[6:0]
out_rd  out  5  destination register; 0 if the format has none
out_rs1  out  5  source register 1; 0 if unused
out_rs2  out  5  source register 2; 0 if unused
out_funct3  out  3  instr[14:12]; 0 for U and J formats
out_funct7  out  7  instr[31:25] for R format, else 0
out_imm  out  XLEN  sign-extended immediate; 0 for R format
out_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
out_rd_we  out  1  format writes rd AND rd!=0
out_illegal  out  1  unknown opcode, or low bits check fails

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, in_ready=1.
  - All data outputs 0. Skid entry is empty.
  - Held instructions are dropped; the first accept after release behaves as from empty.
- Opcode map:
  - R: 0110011.
  - I: 0000011, 0010011, 1100111, 0001111, 1110011.
  - S: 0100011. B: 1100011.
  - U: 0110111, 0010111. J: 1101111.
  - Anything else: fmt=7, illegal=1, rd/rs1/rs2/imm=0, rd_we=0.
- Immediates (sext to XLEN from the leftmost bit, always instr[31]):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}, sign-extended when XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Field usage:
  - R uses rd, rs1, rs2.
  - I uses rd, rs1. S and B use rs1, rs2. U and J use rd.
- Decode is combinational from in_instr. The result is captured into the output register on accept.
- Latency: instruction accepted at edge N is presented with out_valid=1 from N+1.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Transfer = out_valid & out_ready.
  - out_* are held stable while out_valid & !out_ready.
- Skid buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, skid occupied, in_ready=0.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + transfer -> ONE, with new data.
  - ONE + accept + !transfer -> FULL; the new decode goes to the skid.
  - ONE + transfer only -> EMPTY.
  - FULL + transfer -> ONE; skid moves to output, in_ready=1 next cycle.
  - FULL + !transfer -> FULL.
- in_ready is a register equal to !(skid occupied). It never depends combinationally on out_ready.
- Order is strictly preserved; no entry is dropped or duplicated.
- flush=1:
  - Next cycle: EMPTY, out_valid=0, in_ready=1.
  - Flush wins over a simultaneous accept (that instruction is discarded) and over transfer.
  - Data outputs need not be cleared.

Test Plan:
- Reset mid-stream in FULL -> rst_n low asynchronously forces out_valid=0 and in_ready=1 without a clock edge; after release, the first accepted instr appears next cycle.
- in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle fmt=1, rd=1, rs1=0, rs2=0, imm=0xFFFFFFFF (XLEN=32), rd_we=1.
- Branch 0xFE000EE3 (beq x0,x0,-4) -> fmt=3, imm=-4, rd=0, rd_we=0; JAL 0x0000006F with XLEN=64 -> fmt=5, imm=0, rd_we=0 (rd=0).
- Back-to-back 8 instrs, out_ready low for cycles 2-4 -> in_ready drops only after the skid fills; all 8 emerge in order, none duplicated; throughput returns to 1/cycle.
- Illegal: 0x0000007F and 0x00000013 with ILLEGAL_ON_C=1 and bits[1:0] altered to 2'b01 -> illegal=1, fmt=7, imm=0, rd_we=0.
- flush asserted in FULL with a simultaneous in_valid -> next cycle out_valid=0, in_ready=1; the flushed and concurrent instrs never appear.
